// File: rtl/pdm_pkg.sv
// pdm_pkg: shared types and constants for the PDM microphone capture path.
package pdm_pkg;

    localparam int PDM_WORD_BITS = 32;
    localparam int PDM_BITCNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2
    } pdm_state_e;

    // Append one PDM sample at the LSB so the oldest sample ends up in the MSB.
    function automatic logic [PDM_WORD_BITS-1:0] pdm_shift_in(
        input logic [PDM_WORD_BITS-1:0] word_in,
        input logic                     sample_in
    );
        return {word_in[PDM_WORD_BITS-2:0], sample_in};
    endfunction

endpackage

// File: rtl/pdm_clk_div.sv
// pdm_clk_div: generates micClk (CLK_DIV system cycles per half-period) and a
// one-cycle sample strobe in the cycle whose closing edge drives micClk 1->0.
// Held at count 0 with micClk low whenever run is deasserted.
module pdm_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic micClk,
    output logic sample_en
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mic_clk_q;
    logic             mic_clk_d;
    logic             terminal_s;

    // Next-state for the divider counter and micClk toggle, plus the sample strobe.
    always_comb begin
        cnt_d      = cnt_q;
        mic_clk_d  = mic_clk_q;
        terminal_s = (cnt_q == CNT_LAST);
        if (!run) begin
            cnt_d     = '0;
            mic_clk_d = 1'b0;
        end else if (terminal_s) begin
            cnt_d     = '0;
            mic_clk_d = ~mic_clk_q;
        end else begin
            cnt_d     = cnt_q + CNT_W'(1);
        end
        sample_en = run && terminal_s && mic_clk_q;
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign micClk = mic_clk_q;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: framed PDM capture. Runs a warm-up of WARMUP_PERIODS
// micClk periods after each enable, then deserialises 32 samples per word
// (oldest in bit 31) and offers each word on a valid/ready handshake with a
// sticky overflow flag for dropped words.
// Optional feature: define PDM_DROP_CNT_EN to add a saturating 16-bit
// dropped-word counter on output drop_cnt.
module pdm_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int CLK_DIV        = 50,
    parameter int WARMUP_PERIODS = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     micDataPDM,
    output logic                     micClk,
    output logic                     micLRSel,
    output logic [PDM_WORD_BITS-1:0] word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
`ifdef PDM_DROP_CNT_EN
    output logic [15:0]              drop_cnt,
`endif
    output logic                     overflow,
    output logic                     busy
);

    localparam int                      WU_W     = (WARMUP_PERIODS > 1) ? $clog2(WARMUP_PERIODS + 1) : 1;
    localparam logic [WU_W-1:0]         WU_LAST  = WU_W'(WARMUP_PERIODS - 1);
    localparam logic [PDM_BITCNT_W-1:0] BIT_LAST = PDM_BITCNT_W'(PDM_WORD_BITS - 1);

    pdm_state_e                state_q,      state_d;
    logic [WU_W-1:0]           warm_cnt_q,   warm_cnt_d;
    logic [PDM_BITCNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [PDM_WORD_BITS-1:0]  shreg_q,      shreg_d;
    logic [PDM_WORD_BITS-1:0]  word_data_q,  word_data_d;
    logic                      word_valid_q, word_valid_d;
    logic                      overflow_q,   overflow_d;
    logic                      busy_q,       busy_d;
    logic                      complete_s;
    logic                      drop_s;
    logic                      run_s;
    logic                      sample_en_s;
`ifdef PDM_DROP_CNT_EN
    logic [15:0]               drop_cnt_q,   drop_cnt_d;
`endif

    // Divider runs only while active and enabled, so it is already parked
    // (micClk low) on the same edge the FSM falls back to IDLE.
    assign run_s = (state_q != IDLE) && enable;

    pdm_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .reset     (reset),
        .run       (run_s),
        .micClk    (micClk),
        .sample_en (sample_en_s)
    );

    // FSM next state, warm-up/bit counters, shifter and word handshake.
    always_comb begin
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        overflow_d   = overflow_q;
        complete_s   = 1'b0;
        drop_s       = 1'b0;

        case (state_q)
            IDLE: begin
                warm_cnt_d = '0;
                bit_cnt_d  = '0;
                shreg_d    = '0;
                if (enable) begin
                    state_d = WARMUP;
                end else begin
                    state_d = IDLE;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    state_d    = IDLE;
                    warm_cnt_d = '0;
                end else if (sample_en_s) begin
                    if (warm_cnt_q == WU_LAST) begin
                        state_d    = CAPTURE;
                        warm_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WU_W'(1);
                    end
                end else begin
                    state_d = WARMUP;
                end
            end
            CAPTURE: begin
                if (!enable) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end else if (sample_en_s) begin
                    shreg_d    = pdm_shift_in(shreg_q, micDataPDM);
                    bit_cnt_d  = bit_cnt_q + PDM_BITCNT_W'(1);
                    complete_s = (bit_cnt_q == BIT_LAST);
                end else begin
                    state_d = CAPTURE;
                end
            end
            default: begin
                state_d    = IDLE;
                warm_cnt_d = '0;
                bit_cnt_d  = '0;
                shreg_d    = '0;
            end
        endcase

        // A completion wins over a plain consume; a completion into a held word is dropped.
        if (complete_s) begin
            if (!word_valid_q || word_ready) begin
                word_data_d  = shreg_d;
                word_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
                drop_s     = 1'b1;
            end
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end

        busy_d = (state_d != IDLE);
    end

`ifdef PDM_DROP_CNT_EN
    // Saturating count of dropped words.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Dropped-word counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // Control and datapath state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            warm_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign micLRSel   = 1'b0;
    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl: directed bench with a word scoreboard. Stimulus pushes
// expected words; a monitor pops and compares on every accepted word.
// CLK_DIV=2, WARMUP_PERIODS=4: strobe k closes at entry+4k, word n at
// entry+144+128(n-1).
module tb_pdm_capture_ctrl;

    localparam int CLK_DIV = 2;
    localparam int WU      = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        micDataPDM = 1'b0;
    logic        word_ready = 1'b0;
    logic        micClk;
    logic        micLRSel;
    logic [31:0] word_data;
    logic        word_valid;
    logic        overflow;
    logic        busy;
`ifdef PDM_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pat = 32'hAAAA_AAAA;
    int          rise_cnt = 0;
    logic        mic_prev = 1'b0;

    pdm_capture_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .WARMUP_PERIODS (WU)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .micDataPDM (micDataPDM),
        .micClk     (micClk),
        .micLRSel   (micLRSel),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
`ifdef PDM_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Wait until just after edge number c.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the edge number at which word_valid rose, or -1 on timeout.
    task automatic wait_valid_rise(input int bound, output int at);
        logic prev;
        at = -1;
        prev = word_valid;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (word_valid && !prev) begin
                at = cyc;
                break;
            end
            prev = word_valid;
        end
    endtask

    // Data driver: present the next pattern bit just after each micClk rise;
    // the first WU rises after enable belong to warm-up.
    always @(posedge clk) begin
        int j;
        #1;
        if (!busy) begin
            rise_cnt = 0;
        end else if (micClk && !mic_prev) begin
            rise_cnt = rise_cnt + 1;
            if (rise_cnt > WU) begin
                j = (rise_cnt - WU - 1) % 32;
                micDataPDM = pat[31-j];
            end
        end
        mic_prev = micClk;
    end

    // Scoreboard monitor: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", word_data, 32'hxxxx_xxxx);
            end else begin
                check("word_data", word_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int e;
        int e2;
        int at;
        int r1;
        int r2;

        // Reset state.
        enable = 1'b1;
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_micClk", {31'd0, micClk}, 32'd0);
        check("rst_micLRSel", {31'd0, micLRSel}, 32'd0);
        check("rst_word_data", word_data, 32'd0);
        check("rst_word_valid", {31'd0, word_valid}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Pattern phase: three 0xAAAAAAAA words, ready held high.
        exp_q.push_back(32'hAAAA_AAAA);
        exp_q.push_back(32'hAAAA_AAAA);
        exp_q.push_back(32'hAAAA_AAAA);
        reset = 1'b0;
        e = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin
                e = cyc;
                break;
            end
        end
        check("busy_rise", (e < 0) ? 32'd1 : 32'd0, 32'd0);
        r1 = -1;
        r2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (micClk && (r1 < 0)) r1 = cyc;
            else if (micClk && (r1 >= 0) && (r2 < 0) && (cyc - r1 > 1)) r2 = cyc;
            else r1 = r1;
        end
        check("micClk_first_rise", r1, e + CLK_DIV);
        check("micClk_period", r2 - r1, 2 * CLK_DIV);

        wait_valid_rise(300, at);
        check("first_word_time", at, e + 144);
        wait_valid_rise(200, at);
        check("word2_time", at, e + 272);
        wait_valid_rise(200, at);
        check("word3_time", at, e + 400);
        check("no_overflow_pattern", {31'd0, overflow}, 32'd0);

        // Simultaneous ready and completion.
        wait_until(e + 401);
        word_ready = 1'b0;
        pat = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        wait_until(e + 529);
        check("word4_held_valid", {31'd0, word_valid}, 32'd1);
        pat = 32'hC3A5_0F96;
        wait_until(e + 655);
        word_ready = 1'b1;
        exp_q.push_back(32'hC3A5_0F96);
        wait_until(e + 656);
        word_ready = 1'b0;
        check("simul_valid", {31'd0, word_valid}, 32'd1);
        check("simul_data", word_data, 32'hC3A5_0F96);
        check("simul_overflow", {31'd0, overflow}, 32'd0);

        // Back-pressure across a completion: word kept, overflow set.
        wait_until(e + 657);
        pat = 32'h0F0F_0F0F;
        wait_until(e + 700);
        check("bp_overflow_before", {31'd0, overflow}, 32'd0);
        wait_until(e + 790);
        check("bp_data_kept", word_data, 32'hC3A5_0F96);
        check("bp_valid", {31'd0, word_valid}, 32'd1);
        check("bp_overflow", {31'd0, overflow}, 32'd1);
`ifdef PDM_DROP_CNT_EN
        check("bp_drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
        word_ready = 1'b1;
        exp_q.push_back(32'h0F0F_0F0F);
        wait_valid_rise(200, at);
        check("word7_time", at, e + 912);

        // Abort after 10 bits, then re-enable with a fresh pattern.
        wait_until(e + 913);
        pat = 32'hFFFF_FFFF;
        wait_until(e + 954);
        enable = 1'b0;
        wait_until(e + 955);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_micClk", {31'd0, micClk}, 32'd0);
        check("abort_valid", {31'd0, word_valid}, 32'd0);
        pat = 32'h6996_A55A;
        exp_q.push_back(32'h6996_A55A);
        wait_until(e + 960);
        enable = 1'b1;
        e2 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin
                e2 = cyc;
                break;
            end
        end
        check("reenable_entry", e2, e + 961);
        wait_valid_rise(300, at);
        check("reenable_word_time", at, e2 + 144);

        // Asynchronous reset while a word is pending.
        wait_until(e2 + 145);
        word_ready = 1'b0;
        wait_until(e2 + 280);
        check("pre_reset_valid", {31'd0, word_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("areset_micClk", {31'd0, micClk}, 32'd0);
        check("areset_word_data", word_data, 32'd0);
        check("areset_word_valid", {31'd0, word_valid}, 32'd0);
        check("areset_overflow", {31'd0, overflow}, 32'd0);
        check("areset_busy", {31'd0, busy}, 32'd0);
`ifdef PDM_DROP_CNT_EN
        check("areset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_capture_ctrl.md
# pdm_capture_ctrl

Sequencing controller for the PDM microphone capture path. Generates the microphone clock from the system clock and times the sampling of `micDataPDM`. Deserialises exactly 32 samples per word, MSB first, and hands each completed word to the downstream filter over a valid/ready handshake, with overflow detection. It replaces a free-running shifter with a framed, flow-controlled word source.

## Interface
- `CLK_DIV`, 50: system-clock cycles per `micClk` half-period; legal range ≥ 2; 100 MHz / (2·50) = 1 MHz.
- `WARMUP_PERIODS`, 1024: `micClk` periods discarded after each enable, covering microphone start-up.
- `clk` in 1: system clock. All logic is on the rising edge; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: level. 1 = run capture, 0 = stop.
- `micDataPDM` in 1: PDM data from the microphone, already synchronised to `clk` upstream.
- `micClk` out 1: microphone clock, registered output.
- `micLRSel` out 1: channel select, tied 0 (left channel / rising-edge data).
- `word_data` out 32: completed word. The oldest sample is in bit 31.
- `word_valid` out 1: `word_data` holds an unconsumed word.
- `word_ready` in 1: downstream accepts the word.
- `overflow` out 1: sticky flag; a completed word was dropped.
- `busy` out 1: the state machine is not in IDLE.

## Operation
- Reset values: `micClk`=0, `micLRSel`=0, `word_data`=0, `word_valid`=0, `overflow`=0, `busy`=0. All counters are 0 and the state is IDLE.
- Divider: counts 0..CLK_DIV-1 and toggles `micClk` at the terminal count. It runs only in WARMUP and CAPTURE; in IDLE it is held at 0 with `micClk`=0.
- `sample_en`: single-cycle strobe, asserted in the cycle in which the divider drives `micClk` from 1 to 0. `micDataPDM` is shifted in on that edge: `shreg <= {shreg[30:0], micDataPDM}`.
- States:
  - IDLE: `enable`=1 → WARMUP.
  - WARMUP: counts `sample_en` strobes, but samples are not shifted. After WARMUP_PERIODS strobes → CAPTURE, with the bit counter at 0.
  - CAPTURE: each `sample_en` shifts one sample and increments a 5-bit bit counter, which wraps from 31 to 0. On the strobe where the counter is 31, the word is complete.
- `enable`=0 in WARMUP or CAPTURE forces IDLE on the next edge:
  - The partial word and the warm-up count are discarded.
  - A pending `word_valid` word is kept until it is consumed.
- Word completion:
  - If `word_valid`=0, or `word_ready`=1 in the same cycle: `word_data` <= the new word and `word_valid` <= 1.
  - If `word_valid`=1 and `word_ready`=0: the new word is dropped, `word_data` is unchanged, and `overflow` <= 1.
- Consumption: `word_valid`=1 and `word_ready`=1 with no completion in that cycle → `word_valid` <= 0.
- `overflow` is cleared only by `reset`.
- `word_data` is stable while `word_valid`=1 and `word_ready`=0.

## Timing
- `micClk` period is 2·CLK_DIV cycles at 50 % duty. The first rising edge of `micClk` comes CLK_DIV cycles after IDLE→WARMUP.
- First word: `word_valid` rises (WARMUP_PERIODS+32)·2·CLK_DIV cycles after WARMUP entry, ±1 cycle of register latency. This timing is fixed and checked by the bench.
- Latency: `word_valid` rises on the edge after the 32nd `sample_en` cycle.
- Steady state: one word every 64·CLK_DIV cycles.
- Asynchronous `reset` mid-word clears everything immediately. Capture restarts from WARMUP once `reset` is released with `enable`=1.

## Configuration
- `PDM_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` [15:0], which increments on every dropped word and saturates at 0xFFFF.
  - Reset value is 0.
  - `overflow` still operates.
- `PDM_DROP_CNT_EN` undefined: the port and counter are absent; only the sticky `overflow` is present.

## Structure
- Package `pdm_pkg`:
  - state enum `{IDLE, WARMUP, CAPTURE}`;
  - `PDM_WORD_BITS`=32;
  - `PDM_BITCNT_W`=5.
- Sub-module `pdm_clk_div`:
  - parameter CLK_DIV;
  - ports `clk`, `reset`, `run`, `micClk`, `sample_en`.
- The FSM, shift register, bit counter and handshake register stay in the top module.

## Test plan
- Bench setup: CLK_DIV=2 and WARMUP_PERIODS=4, unless stated otherwise.
- Reset and warm-up: release `reset` with `enable`=1 → `micClk` period is 4 cycles, there is no `word_valid` during 4 warm-up periods, and the first `word_valid` comes 36 `micClk` periods after enable.
- Pattern: drive alternating 1,0 per `sample_en`, starting with 1, with `word_ready`=1 → every word is 0xAAAAAAAA, one every 128 cycles, with no overflow.
- Back-pressure: hold `word_ready`=0 across two completions → `word_data` keeps word 1, `overflow`=1, and `drop_cnt`=1 when the macro is defined.
- Simultaneous ready and complete: pulse `word_ready` in the exact completion cycle → the new word is loaded, `word_valid` stays 1, and `overflow` stays 0.
- Abort: drop `enable` after 10 bits of a word → IDLE next cycle, `micClk`=0, and `busy`=0. On re-enable, the first word again appears after full warm-up and contains no stale bits.
- Async reset: assert `reset` mid-cycle while `word_valid`=1 → all outputs go to their reset values immediately, without waiting for a clock edge.
